// File: rtl/analog_status_sampler.sv
// rtl/analog_status_sampler.sv - synchronise, debounce and summarise analog flags into four status words
// Optional: define ANALOG_STATUS_FALL_STICKY_EN to add sticky fall flags in status_1[31:16].
module analog_status_sampler #(
    parameter int NUM_FLAGS       = 8,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int SYNC_STAGES     = 2
) (
    input  logic                 clk_in,
    input  logic                 reset_n,
    input  logic [NUM_FLAGS-1:0] flags_async,
    input  logic                 clear_sticky,
    input  logic [NUM_FLAGS-1:0] clear_mask,
    output logic [31:0]          status_0,
    output logic [31:0]          status_1,
    output logic [31:0]          status_2,
    output logic [31:0]          status_3
);

    localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0][NUM_FLAGS-1:0] sync_q;
    logic [NUM_FLAGS-1:0]                  synced;
    logic [NUM_FLAGS-1:0]                  deb, deb_next;
    logic [NUM_FLAGS-1:0][7:0]             db_cnt, db_cnt_next;
    logic [NUM_FLAGS-1:0]                  rise_sticky, rise_sticky_next;
    logic [NUM_FLAGS-1:0][3:0]             rise_cnt, rise_cnt_next;
    logic [15:0]                           trans_cnt, trans_cnt_next;
    logic [NUM_FLAGS-1:0]                  rise, clr_sel;

    assign synced = sync_q[SYNC_STAGES-1];

    always_comb begin
        deb_next         = deb;
        db_cnt_next      = db_cnt;
        rise_cnt_next    = rise_cnt;
        trans_cnt_next   = trans_cnt;
        for (int i = 0; i < NUM_FLAGS; i++) begin
            if (synced[i] == deb[i]) begin
                db_cnt_next[i] = 8'd0;
            end else if (db_cnt[i] == DB_LAST) begin
                deb_next[i]    = synced[i];
                db_cnt_next[i] = 8'd0;
            end else begin
                db_cnt_next[i] = db_cnt[i] + 8'd1;
            end
        end
        rise    = deb_next & ~deb;
        clr_sel = clear_sticky ? clear_mask : '0;
        // Set wins over clear so a rise coinciding with a clear is never lost.
        rise_sticky_next = (rise_sticky & ~clr_sel) | rise;
        for (int i = 0; i < NUM_FLAGS; i++) begin
            if (clr_sel[i]) begin
                rise_cnt_next[i] = {3'b000, rise[i]};
            end else if (rise[i] && rise_cnt[i] != 4'hF) begin
                rise_cnt_next[i] = rise_cnt[i] + 4'd1;
            end
        end
        if (deb_next != deb) begin
            trans_cnt_next = trans_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            sync_q      <= '0;
            deb         <= '0;
            db_cnt      <= '0;
            rise_sticky <= '0;
            rise_cnt    <= '0;
            trans_cnt   <= '0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], flags_async};
            deb         <= deb_next;
            db_cnt      <= db_cnt_next;
            rise_sticky <= rise_sticky_next;
            rise_cnt    <= rise_cnt_next;
            trans_cnt   <= trans_cnt_next;
        end
    end

`ifdef ANALOG_STATUS_FALL_STICKY_EN
    logic [NUM_FLAGS-1:0] fall_sticky, fall_sticky_next;

    always_comb begin
        fall_sticky_next = (fall_sticky & ~clr_sel) | (deb & ~deb_next);
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            fall_sticky <= '0;
        end else begin
            fall_sticky <= fall_sticky_next;
        end
    end

    assign status_1 = {16'(fall_sticky), 16'(rise_sticky)};
`else
    assign status_1 = {16'h0000, 16'(rise_sticky)};
`endif

    assign status_0 = 32'(deb);
    assign status_2 = 32'(rise_cnt);
    assign status_3 = {trans_cnt, 8'(NUM_FLAGS), 8'(DEBOUNCE_CYCLES)};

endmodule

// File: tb/tb_analog_status_sampler.sv
// tb/tb_analog_status_sampler.sv - table-driven and randomized bench for analog_status_sampler
module tb_analog_status_sampler;

    localparam int NF = 8;
    localparam int DB = 4;
    localparam int SS = 2;
`ifdef ANALOG_STATUS_FALL_STICKY_EN
    localparam bit FALL_EN = 1'b1;
`else
    localparam bit FALL_EN = 1'b0;
`endif

    logic        clk_in = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  flags_async = 8'h00;
    logic        clear_sticky = 1'b0;
    logic [7:0]  clear_mask = 8'h00;
    logic [31:0] status_0, status_1, status_2, status_3;

    always #5 clk_in = ~clk_in;

    analog_status_sampler #(.NUM_FLAGS(NF), .DEBOUNCE_CYCLES(DB), .SYNC_STAGES(SS)) dut (
        .clk_in      (clk_in),
        .reset_n     (reset_n),
        .flags_async (flags_async),
        .clear_sticky(clear_sticky),
        .clear_mask  (clear_mask),
        .status_0    (status_0),
        .status_1    (status_1),
        .status_2    (status_2),
        .status_3    (status_3)
    );

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a flag's level flips once the last DB synchroniser outputs
    // (raw samples delayed SS edges) all disagree with the current level.
    logic [7:0] samp_q[$];
    logic [7:0] m_deb, m_rise, m_fall, m_nd, m_s;
    int         m_rc[NF];
    int         m_trans;
    bit         m_stable;

    function automatic logic [7:0] sample_at(input int back);
        if (back < samp_q.size()) return samp_q[samp_q.size() - 1 - back];
        return 8'h00;
    endfunction

    task automatic model_reset();
        samp_q.delete();
        m_deb = 8'h00; m_rise = 8'h00; m_fall = 8'h00; m_trans = 0;
        for (int i = 0; i < NF; i++) m_rc[i] = 0;
    endtask

    always begin
        @(posedge clk_in or negedge reset_n);
        if (!reset_n) begin
            model_reset();
        end else begin
            samp_q.push_back(flags_async);
            if (samp_q.size() > 64) void'(samp_q.pop_front());
            m_nd = m_deb;
            for (int i = 0; i < NF; i++) begin
                m_stable = 1'b1;
                for (int k = SS; k < SS + DB; k++) begin
                    m_s = sample_at(k);
                    if (m_s[i] == m_deb[i]) m_stable = 1'b0;
                end
                if (m_stable) m_nd[i] = ~m_deb[i];
            end
            if (m_nd != m_deb) m_trans = (m_trans + 1) % 65536;
            for (int i = 0; i < NF; i++) begin
                if (clear_sticky && clear_mask[i]) begin
                    m_rise[i] = 1'b0; m_fall[i] = 1'b0; m_rc[i] = 0;
                end
                if (m_nd[i] && !m_deb[i]) begin
                    m_rise[i] = 1'b1;
                    m_rc[i] = (m_rc[i] < 15) ? m_rc[i] + 1 : 15;
                end
                if (!m_nd[i] && m_deb[i]) m_fall[i] = 1'b1;
            end
            m_deb = m_nd;
        end
    end

    function automatic logic [31:0] m_s2();
        logic [31:0] r = 32'h0;
        for (int i = 0; i < NF; i++) r[4*i +: 4] = 4'(m_rc[i]);
        return r;
    endfunction

    always @(negedge clk_in) begin
        if (mon_en) begin
            check("mon_s0", status_0, {24'h0, m_deb});
            check("mon_s1", status_1, {8'h0, FALL_EN ? m_fall : 8'h00, 8'h0, m_rise});
            check("mon_s2", status_2, m_s2());
            check("mon_s3", status_3, {16'(m_trans), 16'h0804});
        end
    end

    typedef struct {
        logic [7:0]  flags;
        logic        clr;
        logic [7:0]  mask;
        int          cyc;
        logic [7:0]  s0;
        logic [7:0]  rise;
        logic [7:0]  fall;
        logic [31:0] s2;
        logic [15:0] trans;
    } step_t;

    step_t steps[$];

    task automatic add(input logic [7:0] f, input logic c, input logic [7:0] m, input int n,
                       input logic [7:0] s0, input logic [7:0] r, input logic [7:0] fl,
                       input logic [31:0] s2, input logic [15:0] t);
        step_t s;
        s.flags = f; s.clr = c; s.mask = m; s.cyc = n;
        s.s0 = s0; s.rise = r; s.fall = fl; s.s2 = s2; s.trans = t;
        steps.push_back(s);
    endtask

    task automatic check_all(input string tag, input logic [7:0] s0, input logic [7:0] r,
                             input logic [7:0] fl, input logic [31:0] s2, input logic [15:0] t);
        check({tag, "_s0"}, status_0, {24'h0, s0});
        check({tag, "_s1"}, status_1, {8'h0, FALL_EN ? fl : 8'h00, 8'h0, r});
        check({tag, "_s2"}, status_2, s2);
        check({tag, "_s3"}, status_3, {t, 16'h0804});
    endtask

    initial begin
        add(8'h05, 0, 8'h00, 5,  8'h00, 8'h00, 8'h00, 32'h0000_0000, 16'd0);
        add(8'h05, 0, 8'h00, 1,  8'h05, 8'h05, 8'h00, 32'h0000_0101, 16'd1);
        add(8'h0D, 0, 8'h00, 3,  8'h05, 8'h05, 8'h00, 32'h0000_0101, 16'd1);
        add(8'h05, 0, 8'h00, 10, 8'h05, 8'h05, 8'h00, 32'h0000_0101, 16'd1);
        add(8'h0D, 0, 8'h00, 4,  8'h05, 8'h05, 8'h00, 32'h0000_0101, 16'd1);
        add(8'h05, 0, 8'h00, 2,  8'h0D, 8'h0D, 8'h00, 32'h0000_1101, 16'd2);
        add(8'h05, 0, 8'h00, 3,  8'h0D, 8'h0D, 8'h00, 32'h0000_1101, 16'd2);
        add(8'h05, 0, 8'h00, 1,  8'h05, 8'h0D, 8'h08, 32'h0000_1101, 16'd3);
        add(8'h05, 1, 8'h01, 1,  8'h05, 8'h0C, 8'h08, 32'h0000_1100, 16'd3);
        add(8'h05, 1, 8'h00, 1,  8'h05, 8'h0C, 8'h08, 32'h0000_1100, 16'd3);
        add(8'h07, 0, 8'h00, 5,  8'h05, 8'h0C, 8'h08, 32'h0000_1100, 16'd3);
        add(8'h07, 1, 8'h02, 1,  8'h07, 8'h0E, 8'h08, 32'h0000_1110, 16'd4);
        add(8'h03, 0, 8'h00, 6,  8'h03, 8'h0E, 8'h0C, 32'h0000_1110, 16'd5);
        add(8'h07, 0, 8'h00, 6,  8'h07, 8'h0E, 8'h0C, 32'h0000_1210, 16'd6);
        add(8'h07, 1, 8'h04, 1,  8'h07, 8'h0A, 8'h08, 32'h0000_1010, 16'd6);

        repeat (3) @(negedge clk_in);
        check_all("reset", 8'h00, 8'h00, 8'h00, 32'h0, 16'd0);
        reset_n = 1'b1;
        mon_en = 1'b1;

        for (int i = 0; i < steps.size(); i++) begin
            flags_async = steps[i].flags;
            clear_sticky = steps[i].clr;
            clear_mask = steps[i].mask;
            repeat (steps[i].cyc) @(negedge clk_in);
            clear_sticky = 1'b0;
            check_all($sformatf("tbl%0d", i), steps[i].s0, steps[i].rise, steps[i].fall,
                      steps[i].s2, steps[i].trans);
        end

        // 17 debounced rises on flag 0 saturate its counter.
        for (int n = 0; n < 17; n++) begin
            flags_async = 8'h06;
            repeat (6) @(negedge clk_in);
            flags_async = 8'h07;
            repeat (6) @(negedge clk_in);
        end
        check("sat_s2", status_2, 32'h0000_101F);
        check("sat_s3", status_3, 32'h0028_0804);
        clear_sticky = 1'b1;
        clear_mask = 8'h01;
        @(negedge clk_in);
        clear_sticky = 1'b0;
        check("satclr_s2", status_2, 32'h0000_1010);
        check("satclr_s1", status_1, {8'h0, FALL_EN ? 8'h08 : 8'h00, 8'h0, 8'h0A});

        // Asynchronous reset mid-cycle, with flags held high across the release.
        #2 reset_n = 1'b0;
        flags_async = 8'h81;
        #1 check_all("async_rst", 8'h00, 8'h00, 8'h00, 32'h0, 16'd0);
        repeat (2) @(negedge clk_in);
        reset_n = 1'b1;
        repeat (5) @(negedge clk_in);
        check_all("post_rst5", 8'h00, 8'h00, 8'h00, 32'h0, 16'd0);
        @(negedge clk_in);
        check_all("post_rst6", 8'h81, 8'h81, 8'h00, 32'h1000_0001, 16'd1);

        for (int n = 0; n < 300; n++) begin
            flags_async = 8'($urandom);
            clear_sticky = ($urandom_range(0, 7) == 0);
            clear_mask = 8'($urandom);
            repeat ($urandom_range(1, 9)) @(negedge clk_in);
        end
        clear_sticky = 1'b0;
        repeat (10) @(negedge clk_in);

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
